// File: rtl/usb_pll_pkg.sv
// usb_pll_pkg: shared state encoding, counter-width helpers and reset values for the USB PLL supervisor.
package usb_pll_pkg;

    typedef enum logic [2:0] {PRST, WAIT, STAB, REL, RUN, FAIL} state_t;

    function automatic int cnt_w(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam logic       RST_PLL_RESET = 1'b1;
    localparam logic       RST_LOCKED    = 1'b0;
    localparam logic       RST_FAIL      = 1'b0;
    localparam logic [7:0] LOST_SAT      = 8'hFF;

endpackage

// File: rtl/usb_sync2.sv
// usb_sync2: two-flop synchroniser with rising/falling edge detect on the synchronised level.
module usb_sync2 (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q,
    output logic o_rise,
    output logic o_fall
);

    logic r_s1, r_s2, r_s3;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) {r_s1, r_s2, r_s3} <= '0;
        else {r_s1, r_s2, r_s3} <= {i_d, r_s1, r_s2};
    end

    assign o_q    = r_s2;
    assign o_rise = r_s2 & ~r_s3;
    assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/usb_pll_supervisor.sv
// usb_pll_supervisor: USB PLL lock supervisor and staggered domain reset sequencer.
// Optional output-frequency check enabled by USB_PLL_SUPERVISOR_FREQ_CHK_EN.
module usb_pll_supervisor
    import usb_pll_pkg::*;
#(
    parameter int PLL_RST_CYC      = 16,
    parameter int LOCK_TIMEOUT_CYC = 24000,
    parameter int LOCK_STABLE_CYC  = 240,
    parameter int NUM_DOM          = 2,
    parameter int STAGGER_CYC      = 8,
    parameter int MAX_RETRY        = 7
`ifdef USB_PLL_SUPERVISOR_FREQ_CHK_EN
  , parameter int FREQ_WIN_CYC     = 1024,
    parameter int FREQ_MIN         = 1,
    parameter int FREQ_MAX         = FREQ_WIN_CYC
`endif
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_pll_lock,
    input  logic               i_relock_req,
`ifdef USB_PLL_SUPERVISOR_FREQ_CHK_EN
    input  logic               i_pll_tick,
`endif
    output logic               o_pll_reset,
    output logic [NUM_DOM-1:0] o_dom_rst_n,
    output logic               o_locked,
    output logic               o_fail,
    output logic [3:0]         o_retry_cnt,
    output logic [7:0]         o_lost_cnt
);

    localparam int REL_CYC = (NUM_DOM - 1) * STAGGER_CYC;
    localparam int TW      = cnt_w(imax(imax(PLL_RST_CYC, LOCK_TIMEOUT_CYC), imax(LOCK_STABLE_CYC, REL_CYC)));
    localparam int RW      = cnt_w(MAX_RETRY);

    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic [RW-1:0]      r_retry;
    logic [7:0]         r_lost;
    logic [NUM_DOM-1:0] r_dom;
    logic               r_pll_reset, r_locked, r_fail;
    logic               w_lock_s, w_lock_ok, w_unused_lock_rise, w_unused_lock_fall;
    logic [TW:0]        w_rel_c;
    logic [NUM_DOM-1:0] w_dom_rel;

    usb_sync2 u_lock_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_lock),
        .o_q     (w_lock_s),
        .o_rise  (w_unused_lock_rise),
        .o_fall  (w_unused_lock_fall)
    );

`ifdef USB_PLL_SUPERVISOR_FREQ_CHK_EN
    localparam int FW = cnt_w(FREQ_WIN_CYC);
    logic          w_unused_tick_q, w_tick_rise, w_tick_fall, w_in_chk, w_win_end, w_freq_bad;
    logic [FW-1:0] r_win, r_edges, w_edges_now;

    usb_sync2 u_tick_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_d     (i_pll_tick),
        .o_q     (w_unused_tick_q),
        .o_rise  (w_tick_rise),
        .o_fall  (w_tick_fall)
    );

    assign w_in_chk    = r_state inside {STAB, REL, RUN};
    assign w_win_end   = r_win == FW'(FREQ_WIN_CYC - 1);
    assign w_edges_now = r_edges + FW'(w_tick_rise | w_tick_fall);
    assign w_freq_bad  = w_in_chk && w_win_end && (w_edges_now < FW'(FREQ_MIN) || w_edges_now > FW'(FREQ_MAX));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || !w_in_chk || w_win_end) begin
            r_win   <= '0;
            r_edges <= '0;
        end else begin
            r_win   <= r_win + 1'b1;
            r_edges <= w_edges_now;
        end
    end

    // An out-of-range window is indistinguishable from a dropped lock downstream.
    assign w_lock_ok = w_lock_s & ~w_freq_bad;
`else
    assign w_lock_ok = w_lock_s;
`endif

    // Release mask for the cycle after this edge: domain i is free once i*STAGGER_CYC REL cycles have passed.
    assign w_rel_c = (r_state == REL) ? {1'b0, r_timer} + 1'b1 : '0;

    always_comb begin
        w_dom_rel = '0;
        for (int i = 0; i < NUM_DOM; i++) w_dom_rel[i] = w_rel_c >= (TW + 1)'(i * STAGGER_CYC);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= PRST;
            r_timer     <= '0;
            r_pll_reset <= RST_PLL_RESET;
            r_dom       <= '0;
            r_locked    <= RST_LOCKED;
            r_fail      <= RST_FAIL;
            r_retry     <= '0;
            r_lost      <= '0;
        end else if (i_relock_req && r_state != PRST) begin
            r_state     <= PRST;
            r_timer     <= '0;
            r_pll_reset <= 1'b1;
            r_dom       <= '0;
            r_locked    <= 1'b0;
            r_fail      <= 1'b0;
            r_retry     <= '0;
        end else if (!w_lock_ok && (r_state == REL || r_state == RUN)) begin
            r_state     <= PRST;
            r_timer     <= '0;
            r_pll_reset <= 1'b1;
            r_dom       <= '0;
            r_locked    <= 1'b0;
            r_lost      <= r_lost + {7'd0, r_lost != LOST_SAT};
        end else begin
            case (r_state)
                PRST: begin
                    r_timer <= r_timer + 1'b1;
                    if (r_timer == TW'(PLL_RST_CYC - 1)) begin
                        r_state     <= WAIT;
                        r_timer     <= '0;
                        r_pll_reset <= 1'b0;
                    end
                end
                WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    if (w_lock_ok) begin
                        r_state <= STAB;
                        r_timer <= '0;
                    end else if (r_timer == TW'(LOCK_TIMEOUT_CYC - 1)) begin
                        r_timer     <= '0;
                        r_pll_reset <= 1'b1;
                        r_retry     <= r_retry + 1'b1;
                        r_state     <= (r_retry + 1'b1 == RW'(MAX_RETRY)) ? FAIL : PRST;
                        r_fail      <= r_retry + 1'b1 == RW'(MAX_RETRY);
                    end
                end
                STAB: begin
                    r_timer <= r_timer + 1'b1;
                    if (!w_lock_ok) begin
                        r_state <= WAIT;
                        r_timer <= '0;
                    end else if (r_timer == TW'(LOCK_STABLE_CYC - 1)) begin
                        r_state <= REL;
                        r_timer <= '0;
                        r_dom   <= w_dom_rel;
                    end
                end
                REL: begin
                    r_timer <= r_timer + 1'b1;
                    r_dom   <= w_dom_rel;
                    if (r_timer == TW'(REL_CYC)) begin
                        r_state  <= RUN;
                        r_timer  <= '0;
                        r_locked <= 1'b1;
                        r_retry  <= '0;
                    end
                end
                default: r_timer <= '0;
            endcase
        end
    end

    assign o_pll_reset = r_pll_reset;
    assign o_dom_rst_n = r_dom;
    assign o_locked    = r_locked;
    assign o_fail      = r_fail;
    assign o_retry_cnt = 4'(r_retry);
    assign o_lost_cnt  = r_lost;

endmodule
